// File: rtl/scan_decoder_pkg.sv
// Shared constants for the scan_decoder block: mode and scan-direction encodings.
// Optional down-scanning is enabled in the top level by defining SCAN_DIR_EN.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_prescaler.sv
// Modulo-DIV step prescaler: counts while enabled and flags the terminal count.
// tick_c is combinational and valid for the edge on which the count wraps.
module scan_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // A clear always wins, so no tick is reported on a clearing edge.
    assign tick_c = en && !clr && (cnt == CNT_MAX);

    always_comb begin
        cnt_n = cnt;
        if (clr) begin
            cnt_n = '0;
        end else if (en) begin
            cnt_n = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

endmodule : scan_prescaler

// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct-load and timed scan modes.
// Define SCAN_DIR_EN to add the dir port and allow down-scanning.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  ld,
    input  logic [SEL_W-1:0]      sel,
`ifdef SCAN_DIR_EN
    input  logic                  dir,
`endif
    output logic [2**SEL_W-1:0]   o,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned      OUT_W   = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    logic             mode_q;
    logic             clr_c;
    logic             tick_c;
    logic             down_c;
    logic [SEL_W-1:0] idx_n;
    logic [OUT_W-1:0] o_n;
    logic             wrap_n;

`ifdef SCAN_DIR_EN
    assign down_c = (dir == DIR_DOWN);
`else
    assign down_c = DIR_UP;
`endif

    // Prescaler restarts in direct mode, on any mode change and on every accepted load.
    assign clr_c = (mode != MODE_SCAN) || (mode != mode_q) || (en && ld);

    scan_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr_c),
        .tick_c (tick_c)
    );

    // Load beats a coincident tick; only a real step across the end of range flags wrap.
    always_comb begin
        idx_n  = idx;
        wrap_n = 1'b0;
        if (en) begin
            if (ld) begin
                idx_n = sel;
            end else if (tick_c) begin
                if (down_c) begin
                    idx_n  = idx - SEL_W'(1);
                    wrap_n = (idx == '0);
                end else begin
                    idx_n  = idx + SEL_W'(1);
                    wrap_n = (idx == IDX_MAX);
                end
            end
        end
        o_n = en ? (OUT_W'(1) << idx_n) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            o      <= '0;
            wrap   <= 1'b0;
            mode_q <= MODE_DIRECT;
        end else begin
            idx    <= idx_n;
            o      <= o_n;
            wrap   <= wrap_n;
            mode_q <= mode;
        end
    end

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder: a DIV=4 instance for direct/scan/gating/reset
// checks and a DIV=1 instance for per-edge stepping (and down-scan with SCAN_DIR_EN).
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en, mode, ld;
    logic [1:0] sel;
    logic [3:0] o;
    logic [1:0] idx;
    logic       wrap;

    logic       f_en, f_mode, f_ld;
    logic [1:0] f_sel;
    logic [3:0] f_o;
    logic [1:0] f_idx;
    logic       f_wrap;
`ifdef SCAN_DIR_EN
    logic       dir;
    logic       f_dir;
`endif

    int errors = 0;
    int checks = 0;

    scan_decoder #(.SEL_W(2), .DIV(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .ld   (ld),
        .sel  (sel),
`ifdef SCAN_DIR_EN
        .dir  (dir),
`endif
        .o    (o),
        .idx  (idx),
        .wrap (wrap)
    );

    scan_decoder #(.SEL_W(2), .DIV(1)) u_fast (
        .clk  (clk),
        .rst  (rst),
        .en   (f_en),
        .mode (f_mode),
        .ld   (f_ld),
        .sel  (f_sel),
`ifdef SCAN_DIR_EN
        .dir  (f_dir),
`endif
        .o    (f_o),
        .idx  (f_idx),
        .wrap (f_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        mode   = MODE_DIRECT;
        ld     = 1'b0;
        sel    = 2'd0;
        f_en   = 1'b0;
        f_mode = MODE_DIRECT;
        f_ld   = 1'b0;
        f_sel  = 2'd0;
`ifdef SCAN_DIR_EN
        dir    = DIR_UP;
        f_dir  = DIR_UP;
`endif

        // Reset state, held even with en/ld active
        #1;
        check("rst_o", 32'(o), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        en  = 1'b1;
        ld  = 1'b1;
        sel = 2'd3;
        step();
        step();
        check("rst_hold_o", 32'(o), 32'h0);
        check("rst_hold_idx", 32'(idx), 32'h0);
        rst = 1'b0;

        // Direct mode loads, one cycle latency
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            check("direct_o", 32'(o), 32'h1 << i);
            check("direct_idx", 32'(idx), 32'(i));
            check("direct_wrap", 32'(wrap), 32'h0);
        end

        // Scan DIV=4 from idx 0
        sel = 2'd0;
        step();
        check("scan_start_idx", 32'(idx), 32'h0);
        ld   = 1'b0;
        mode = MODE_SCAN;
        step();
        check("scan_modechg_idx", 32'(idx), 32'h0);
        for (int s = 1; s <= 4; s++) begin
            for (int r = 0; r < 3; r++) begin
                step();
                check("scan_hold_idx", 32'(idx), 32'((s - 1) % 4));
                check("scan_hold_wrap", 32'(wrap), 32'h0);
            end
            step();
            check("scan_step_idx", 32'(idx), 32'(s % 4));
            check("scan_step_o", 32'(o), 32'h1 << (s % 4));
            check("scan_step_wrap", 32'(wrap), (s == 4) ? 32'h1 : 32'h0);
        end
        step();
        check("wrap_one_cycle", 32'(wrap), 32'h0);
        check("wrap_after_idx", 32'(idx), 32'h0);

        // Load coinciding with a tick
        step();
        step();
        check("pre_tick_idx", 32'(idx), 32'h0);
        ld  = 1'b1;
        sel = 2'd2;
        step();
        check("ld_tick_idx", 32'(idx), 32'h2);
        check("ld_tick_o", 32'(o), 32'h4);
        check("ld_tick_wrap", 32'(wrap), 32'h0);
        ld = 1'b0;
        for (int r = 0; r < 3; r++) begin
            step();
            check("ld_hold_idx", 32'(idx), 32'h2);
        end
        step();
        check("ld_next_idx", 32'(idx), 32'h3);

        // Enable gating at idx 1 with prescaler at 1
        ld  = 1'b1;
        sel = 2'd1;
        step();
        check("gate_ld_idx", 32'(idx), 32'h1);
        ld = 1'b0;
        step();
        en = 1'b0;
        for (int r = 0; r < 10; r++) begin
            if (r == 4) begin
                ld  = 1'b1;
                sel = 2'd3;
            end
            step();
            check("gate_o", 32'(o), 32'h0);
            check("gate_idx", 32'(idx), 32'h1);
            check("gate_wrap", 32'(wrap), 32'h0);
        end
        ld = 1'b0;
        en = 1'b1;
        step();
        check("reen_o", 32'(o), 32'h2);
        step();
        check("reen_hold_idx", 32'(idx), 32'h1);
        step();
        check("reen_step_idx", 32'(idx), 32'h2);
        check("reen_step_o", 32'(o), 32'h4);

        // Asynchronous reset between edges at idx 3
        ld  = 1'b1;
        sel = 2'd3;
        step();
        ld = 1'b0;
        check("pre_arst_o", 32'(o), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        check("arst_o", 32'(o), 32'h0);
        check("arst_idx", 32'(idx), 32'h0);
        check("arst_wrap", 32'(wrap), 32'h0);
        en = 1'b0;
        step();
        rst = 1'b0;

        // DIV=1: step every edge, wrap once per 4 cycles
        f_en   = 1'b1;
        f_mode = MODE_SCAN;
        step();
        check("fast_modechg_idx", 32'(f_idx), 32'h0);
        for (int s = 1; s <= 8; s++) begin
            step();
            check("fast_idx", 32'(f_idx), 32'(s % 4));
            check("fast_o", 32'(f_o), 32'h1 << (s % 4));
            check("fast_wrap", 32'(f_wrap), (s % 4 == 0) ? 32'h1 : 32'h0);
        end

`ifdef SCAN_DIR_EN
        // Down-scan from idx 0
        begin
            int exp_d[5] = '{3, 2, 1, 0, 3};
            f_dir = DIR_DOWN;
            for (int s = 0; s < 5; s++) begin
                step();
                check("down_idx", 32'(f_idx), 32'(exp_d[s]));
                check("down_wrap", 32'(f_wrap), (exp_d[s] == 3) ? 32'h1 : 32'h0);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scan_decoder
